vx_barrier_table: RTL
=====================

Name: vx_barrier_table

Overview:
Consumer side of the warp-control barrier request (barrier_t) produced by the warp-control unit. It tracks per-barrier arrival counts and waiting-warp masks, stalls arriving warps and releases them when the local quorum is met. For global barriers it runs a request/response handshake with the socket-level global barrier unit. It sits in the scheduler and drives the barrier-stall mask and the unlock pulses.

Parameters:
NUM_WARPS, 4, warps per core; NW_WIDTH = clog2(NUM_WARPS), minimum 1.
NUM_BARRIERS, 4, barrier slots; NB_WIDTH = clog2(NUM_BARRIERS), minimum 1.
SIZE_W, 2, width of size_m1, equal to max(NW_WIDTH, NC_WIDTH).
CORE_ID, 0, core index reported on global requests.
NC_WIDTH, 2, core-id width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  barrier request from the warp-control unit; one per cycle, always accepted
req_wid  in  NW_WIDTH  requesting warp
req_id  in  NB_WIDTH  barrier id
req_is_global  in  1  global barrier
req_size_m1  in  SIZE_W  participants minus one (warps if local, cores if global)
req_is_noop  in  1  trivially satisfied barrier
stall_mask  out  NUM_WARPS  warps currently blocked on any barrier
unlock_valid  out  1  one-cycle release pulse
unlock_mask  out  NUM_WARPS  warps released by this pulse
gbar_req_valid  out  1  global barrier request
gbar_req_id  out  NB_WIDTH
gbar_req_size_m1  out  SIZE_W
gbar_req_core_id  out  NC_WIDTH  equals CORE_ID
gbar_req_ready  in  1
gbar_rsp_valid  in  1  global barrier complete
gbar_rsp_id  in  NB_WIDTH

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: all slots go to IDLE with count=0 and wmask=0. Outputs reset to stall_mask=0, unlock_valid=0, unlock_mask=0 and gbar_req_valid=0. A pending global request is dropped. Reset mid-operation discards all waiters with no unlock pulse.
- Per-slot state: state{IDLE, LOCAL, GREQ, GWAIT}, count[NW_WIDTH], wmask[NUM_WARPS], size_m1 (latched from the first request).
- is_noop request: no state change, no stall, no unlock.
- Local arrival (is_global=0):
  - If count == req_size_m1, release: unlock_valid=1 and unlock_mask = wmask | (1<<wid) at N+1. The slot's wmask bits clear from stall_mask at N+1. count=0, state=IDLE. The final warp never appears in stall_mask.
  - Otherwise: count+1, wmask |= bit, state=LOCAL, and the stall_mask bit is set at N+1.
  - size_m1=0 releases immediately with unlock_mask = single warp.
- Global arrival (is_global=1):
  - The warp's bit is set in wmask and stall_mask at N+1.
  - If the slot is IDLE: latch size_m1 and go to GREQ.
  - If the slot is already in GREQ or GWAIT: the warp only joins wmask.
- Mode conflict: a request whose is_global differs from an active slot's mode is handled in the slot's current mode.
- A request from a warp already set in the slot's wmask causes no change.
- gbar request arbitration:
  - gbar_req_valid = any slot in GREQ; the lowest-index GREQ slot drives id and size_m1 (combinational from state).
  - Valid, id and size_m1 stay stable until gbar_req_ready.
  - On valid&&ready that slot moves to GWAIT.
- gbar response:
  - gbar_rsp_valid for a slot in GWAIT: unlock_valid=1 and unlock_mask = wmask at N+1; the slot clears to IDLE.
  - A response for a slot not in GWAIT is ignored.
- Simultaneous events:
  - Same slot, request and rsp together: the rsp releases the old wmask. The request starts a new epoch (IDLE→GREQ, wmask = new bit only) and its warp is not included in unlock_mask.
  - Local release and global rsp in the same cycle: unlock_mask = OR of both, single pulse.
- stall_mask is the OR of all slot wmasks, registered.

Decomposition:
- The VX_gpu_pkg additions are bar_state_t (2-bit enum: IDLE/LOCAL/GREQ/GWAIT), gbar_req_t {id, size_m1, core_id} and gbar_rsp_t {id}.
- barrier_t is reused for the request fields.
- The lowest-index GREQ select uses the existing VX_priority_encoder sub-module; the slot array is written inline with generate.

Test Plan:
1. Local id1 size_m1=2; warp0 @c1, warp2 @c3 → stall_mask 0001 then 0101; warp3 @c5 → c6 unlock_valid=1, unlock_mask=1101, stall_mask=0000; reuse id1 counts from 0.
2. req_is_noop=1 (warp1, id0), and local size_m1=0 (warp2) → noop: no stall/unlock; size_m1=0: unlock_mask=0100 next cycle, stall_mask stays 0.
3. Global id0 size_m1=3 from warp1 → stall_mask 0010, gbar_req_valid=1 id0 size 3 core CORE_ID; hold ready=0 5 cycles → outputs stable; ready=1 → valid drops; warp2 global id0 joins (0110); gbar_rsp id0 → unlock_mask=0110, stall_mask=0000.
4. Global id2 and id1 both GREQ, ready=1 → id1 issued first, id2 next cycle; rsp id2 releases only id2 waiters.
5. Local id3 with warps 0,1 waiting, assert reset 1 cycle → stall_mask=0, no unlock; next gather on id3 needs full quorum again.
6. gbar_rsp id0 same cycle as global req warp3 id0 → unlock_mask excludes warp3; id0 back in GREQ with wmask=1000.

Source files
------------

// File: rtl/vx_barrier_table_pkg.sv
// Shared types for the barrier table: slot state, global-barrier request/response
// payloads and the warp-control barrier request, sized for the default configuration.
package vx_barrier_table_pkg;

    localparam int unsigned BAR_NW_WIDTH = 2;
    localparam int unsigned BAR_NB_WIDTH = 2;
    localparam int unsigned BAR_NC_WIDTH = 2;
    localparam int unsigned BAR_SIZE_W   = 2;

    // Per-slot barrier state
    typedef enum logic [1:0] {
        BAR_IDLE  = 2'd0,
        BAR_LOCAL = 2'd1,
        BAR_GREQ  = 2'd2,
        BAR_GWAIT = 2'd3
    } bar_state_t;

    // Request from the warp-control unit
    typedef struct packed {
        logic                    valid;
        logic [BAR_NB_WIDTH-1:0] id;
        logic                    is_global;
        logic [BAR_SIZE_W-1:0]   size_m1;
        logic                    is_noop;
    } barrier_t;

    // Request to the socket-level global barrier unit
    typedef struct packed {
        logic [BAR_NB_WIDTH-1:0] id;
        logic [BAR_SIZE_W-1:0]   size_m1;
        logic [BAR_NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    // Completion from the socket-level global barrier unit
    typedef struct packed {
        logic [BAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/vx_barrier_table_prio_enc.sv
// Lowest-index priority encoder.
// Ports: req (request vector), idx_c (index of lowest set bit), valid_c (any bit set).
module vx_barrier_table_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx_c,
    output logic         valid_c
);

    // Scan from the top so the lowest set bit is written last and wins
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_barrier_table.sv
// Barrier table: tracks per-barrier arrivals and waiting warps, stalls arriving
// warps and releases them on local quorum or on global-barrier completion.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_*                         barrier request from warp control (always accepted)
//   stall_mask                    warps blocked on any barrier (registered)
//   unlock_valid, unlock_mask     one-cycle release pulse and released warps (registered)
//   gbar_req_*                    global barrier request (from slot state, held until ready)
//   gbar_rsp_valid, gbar_rsp_id   global barrier completion
module vx_barrier_table
    import vx_barrier_table_pkg::*;
#(
    parameter int unsigned NUM_WARPS    = 4,
    parameter int unsigned NUM_BARRIERS = 4,
    parameter int unsigned SIZE_W       = 2,
    parameter int unsigned CORE_ID      = 0,
    parameter int unsigned NC_WIDTH     = 2,
    localparam int unsigned NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int unsigned NB_WIDTH    = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [NW_WIDTH-1:0]   req_wid,
    input  logic [NB_WIDTH-1:0]   req_id,
    input  logic                  req_is_global,
    input  logic [SIZE_W-1:0]     req_size_m1,
    input  logic                  req_is_noop,
    output logic [NUM_WARPS-1:0]  stall_mask,
    output logic                  unlock_valid,
    output logic [NUM_WARPS-1:0]  unlock_mask,
    output logic                  gbar_req_valid,
    output logic [NB_WIDTH-1:0]   gbar_req_id,
    output logic [SIZE_W-1:0]     gbar_req_size_m1,
    output logic [NC_WIDTH-1:0]   gbar_req_core_id,
    input  logic                  gbar_req_ready,
    input  logic                  gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]   gbar_rsp_id
);

    bar_state_t           state_q [NUM_BARRIERS];
    bar_state_t           state_d [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  count_q [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  count_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
    logic [SIZE_W-1:0]    size_q  [NUM_BARRIERS];
    logic [SIZE_W-1:0]    size_d  [NUM_BARRIERS];

    logic [NUM_WARPS-1:0]    stall_d;
    logic                    unlock_valid_d;
    logic [NUM_WARPS-1:0]    unlock_mask_d;
    logic [NUM_WARPS-1:0]    wbit_c;
    logic [NUM_BARRIERS-1:0] greq_c;
    logic [NB_WIDTH-1:0]     sel_idx_c;
    logic                    sel_valid_c;

    assign wbit_c = NUM_WARPS'(1) << req_wid;

    // Slots currently asking for the global barrier
    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_greq
        assign greq_c[g] = (state_q[g] == BAR_GREQ);
    end

    vx_barrier_table_prio_enc #(
        .N (NUM_BARRIERS),
        .W (NB_WIDTH)
    ) u_greq_sel (
        .req     (greq_c),
        .idx_c   (sel_idx_c),
        .valid_c (sel_valid_c)
    );

    // Request fields come straight from slot state, so they hold until accepted
    assign gbar_req_valid   = sel_valid_c;
    assign gbar_req_id      = sel_idx_c;
    assign gbar_req_size_m1 = size_q[sel_idx_c];
    assign gbar_req_core_id = NC_WIDTH'(CORE_ID);

    // Slot next-state. Order: response, then grant, then the new request, so a
    // request landing with a response starts a fresh epoch on the cleared slot.
    always_comb begin
        logic hit;
        logic as_local;
        stall_d        = '0;
        unlock_valid_d = 1'b0;
        unlock_mask_d  = '0;
        hit            = 1'b0;
        as_local       = 1'b0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            wmask_d[i] = wmask_q[i];
            size_d[i]  = size_q[i];

            if (gbar_rsp_valid && (gbar_rsp_id == NB_WIDTH'(i)) && (state_q[i] == BAR_GWAIT)) begin
                unlock_valid_d = 1'b1;
                unlock_mask_d  = unlock_mask_d | wmask_q[i];
                state_d[i]     = BAR_IDLE;
                wmask_d[i]     = '0;
                count_d[i]     = '0;
            end

            if (sel_valid_c && gbar_req_ready && (sel_idx_c == NB_WIDTH'(i))) begin
                state_d[i] = BAR_GWAIT;
            end

            // Duplicate arrivals from an already-waiting warp are dropped
            hit = req_valid && !req_is_noop && (req_id == NB_WIDTH'(i))
                  && ((wmask_d[i] & wbit_c) == '0);

            // An active slot keeps its own mode regardless of the request's flag
            as_local = (state_d[i] == BAR_LOCAL) || ((state_d[i] == BAR_IDLE) && !req_is_global);

            if (hit) begin
                if (as_local) begin
                    if (SIZE_W'(count_d[i]) == req_size_m1) begin
                        unlock_valid_d = 1'b1;
                        unlock_mask_d  = unlock_mask_d | wmask_d[i] | wbit_c;
                        state_d[i]     = BAR_IDLE;
                        wmask_d[i]     = '0;
                        count_d[i]     = '0;
                    end else begin
                        if (state_d[i] == BAR_IDLE) begin
                            size_d[i] = req_size_m1;
                        end
                        state_d[i] = BAR_LOCAL;
                        count_d[i] = count_d[i] + NW_WIDTH'(1);
                        wmask_d[i] = wmask_d[i] | wbit_c;
                    end
                end else begin
                    wmask_d[i] = wmask_d[i] | wbit_c;
                    if (state_d[i] == BAR_IDLE) begin
                        size_d[i]  = req_size_m1;
                        state_d[i] = BAR_GREQ;
                    end
                end
            end

            stall_d = stall_d | wmask_d[i];
        end
    end

    // Slot and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= BAR_IDLE;
                count_q[i] <= '0;
                wmask_q[i] <= '0;
                size_q[i]  <= '0;
            end
            stall_mask   <= '0;
            unlock_valid <= 1'b0;
            unlock_mask  <= '0;
        end else begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                wmask_q[i] <= wmask_d[i];
                size_q[i]  <= size_d[i];
            end
            stall_mask   <= stall_d;
            unlock_valid <= unlock_valid_d;
            unlock_mask  <= unlock_mask_d;
        end
    end

endmodule
